ibex_aes_arbiter: RTL and testbench

Shares one AES-128 cipher core among several requesters (operand-A decrypt, operand-B decrypt, result encrypt) in the secure ALU path. It arbitrates round-robin, keeps at most one operation outstanding, and routes each result back to its requester. It also flags key-invalid requests and, optionally, cipher timeouts. It sits between the secure ALU sequencing FSM and a single cipher instance, which replaces three dedicated cipher instances.

---
 rtl/ibex_pkg.sv | 14 +
 rtl/ibex_aes_rr_picker.sv | 31 +++
 rtl/ibex_aes_arbiter.sv | 139 +++++++++++++
 tb/tb_ibex_aes_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_pkg.sv
// Shared Ibex definitions used by the AES cipher arbiter.
// Holds the arbiter FSM state type and the cipher block width.
package ibex_pkg;

    localparam int unsigned AesBlockW = 128;

    typedef enum logic [1:0] {
        AES_ARB_IDLE,
        AES_ARB_ISSUE,
        AES_ARB_WAIT,
        AES_ARB_RESP
    } aes_arb_state_e;

endpackage

// File: rtl/ibex_aes_rr_picker.sv
// Combinational round-robin picker: the lowest requesting index at or
// above ptr wins, wrapping past NumReq-1 back to 0.
module ibex_aes_rr_picker #(
    parameter int unsigned NumReq = 3,
    localparam int unsigned IdxW  = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req,
    input  logic [IdxW-1:0]   ptr,
    output logic [NumReq-1:0] gnt,
    output logic [IdxW-1:0]   idx
);

    logic [IdxW-1:0] cand;
    logic            found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NumReq; k++) begin
            cand = IdxW'((int'(ptr) + k) % NumReq);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/ibex_aes_arbiter.sv
// Round-robin arbiter sharing one AES-128 cipher among secure ALU requesters.
// Define IBEX_AES_ARB_TIMEOUT_EN to abort operations the cipher never answers.
module ibex_aes_arbiter
    import ibex_pkg::*;
#(
    parameter int unsigned NumReq        = 3,
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          key_valid_i,
    input  logic [NumReq-1:0]             req_valid_i,
    output logic [NumReq-1:0]             req_ready_o,
    input  logic [NumReq*AesBlockW-1:0]   req_data_i,
    input  logic [NumReq-1:0]             req_decrypt_i,
    output logic [NumReq-1:0]             rsp_valid_o,
    output logic [AesBlockW-1:0]          rsp_data_o,
    output logic                          rsp_error_o,
    output logic                          core_valid_o,
    output logic [AesBlockW-1:0]          core_data_o,
    output logic                          core_decrypt_o,
    input  logic                          core_valid_i,
    input  logic [AesBlockW-1:0]          core_data_i,
    output logic                          busy_o
);

    localparam int unsigned IdxW = $clog2(NumReq);

    aes_arb_state_e       state_q;
    logic [IdxW-1:0]      rr_q, id_q, pick_idx;
    logic [NumReq-1:0]    pick_gnt, id_oh, rsp_valid_q;
    logic [AesBlockW-1:0] pick_data, data_q, rsp_data_q;
    logic                 pick_dec, mode_q, err_q, err_d;
    logic                 rsp_err_q, core_valid_q, tmo_hit;

    ibex_aes_rr_picker #(
        .NumReq (NumReq)
    ) u_picker (
        .req (req_valid_i),
        .ptr (rr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (pick_gnt[i]) pick_data = req_data_i[AesBlockW*i +: AesBlockW];
        end
    end

    assign pick_dec    = |(req_decrypt_i & pick_gnt);
    assign id_oh       = NumReq'(1) << id_q;
    // A key lost at any point of the operation poisons its result.
    assign err_d       = err_q | ~key_valid_i;
    assign req_ready_o = (rst_ni && state_q == AES_ARB_IDLE) ? pick_gnt : '0;

`ifdef IBEX_AES_ARB_TIMEOUT_EN
    logic [7:0] tmo_q;
    assign tmo_hit = (tmo_q == 8'(TimeoutCycles - 1));
`else
    localparam int unsigned unused_tmo = TimeoutCycles;
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= AES_ARB_IDLE;
            rr_q         <= '0;
            id_q         <= '0;
            data_q       <= '0;
            mode_q       <= 1'b0;
            err_q        <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            core_valid_q <= 1'b0;
`ifdef IBEX_AES_ARB_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            core_valid_q <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_err_q    <= 1'b0;
            unique case (state_q)
                AES_ARB_IDLE: begin
                    if (|req_valid_i) begin
                        id_q   <= pick_idx;
                        data_q <= pick_data;
                        mode_q <= pick_dec;
                        err_q  <= ~key_valid_i;
                        if (key_valid_i) begin
                            state_q      <= AES_ARB_ISSUE;
                            core_valid_q <= 1'b1;
                        end else begin
                            state_q     <= AES_ARB_RESP;
                            rsp_data_q  <= '0;
                            rsp_valid_q <= pick_gnt;
                            rsp_err_q   <= 1'b1;
                        end
                    end
                end
                AES_ARB_ISSUE, AES_ARB_WAIT: begin
                    err_q <= err_d;
                    if (core_valid_i) begin
                        state_q     <= AES_ARB_RESP;
                        rsp_valid_q <= id_oh;
                        rsp_err_q   <= err_d;
                        rsp_data_q  <= err_d ? '0 : core_data_i;
                    end else if (state_q == AES_ARB_WAIT && tmo_hit) begin
                        state_q     <= AES_ARB_RESP;
                        rsp_valid_q <= id_oh;
                        rsp_err_q   <= 1'b1;
                        rsp_data_q  <= '0;
                    end else begin
                        state_q <= AES_ARB_WAIT;
                    end
`ifdef IBEX_AES_ARB_TIMEOUT_EN
                    tmo_q <= (state_q == AES_ARB_ISSUE) ? '0 : tmo_q + 8'd1;
`endif
                end
                AES_ARB_RESP: begin
                    rr_q    <= (id_q == IdxW'(NumReq - 1)) ? '0 : id_q + IdxW'(1);
                    state_q <= AES_ARB_IDLE;
                end
                default: state_q <= AES_ARB_IDLE;
            endcase
        end
    end

    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_data_o     = rsp_data_q;
    assign rsp_error_o    = rsp_err_q;
    assign core_valid_o   = core_valid_q;
    assign core_data_o    = data_q;
    assign core_decrypt_o = mode_q;
    assign busy_o         = (state_q != AES_ARB_IDLE);

endmodule

// File: tb/tb_ibex_aes_arbiter.sv
// Randomized bench for ibex_aes_arbiter driving a stub cipher; expected
// traffic comes from a per-operation timeline model (grant, answer, response).
module tb_ibex_aes_arbiter;
    import ibex_pkg::*;

    localparam int N   = 3;
    localparam int Tmo = 16;

    logic                   clk_i         = 1'b0;
    logic                   rst_ni        = 1'b0;
    logic                   key_valid_i   = 1'b0;
    logic [N-1:0]           req_valid_i   = '0;
    logic [N-1:0]           req_ready_o;
    logic [N*AesBlockW-1:0] req_data_i    = '0;
    logic [N-1:0]           req_decrypt_i = '0;
    logic [N-1:0]           rsp_valid_o;
    logic [AesBlockW-1:0]   rsp_data_o;
    logic                   rsp_error_o;
    logic                   core_valid_o;
    logic [AesBlockW-1:0]   core_data_o;
    logic                   core_decrypt_o;
    logic                   core_valid_i  = 1'b0;
    logic [AesBlockW-1:0]   core_data_i   = '0;
    logic                   busy_o;

    always #5 clk_i = ~clk_i;

    ibex_aes_arbiter #(
        .NumReq        (N),
        .TimeoutCycles (Tmo)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .key_valid_i    (key_valid_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_data_i     (req_data_i),
        .req_decrypt_i  (req_decrypt_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_data_o     (rsp_data_o),
        .rsp_error_o    (rsp_error_o),
        .core_valid_o   (core_valid_o),
        .core_data_o    (core_data_o),
        .core_decrypt_o (core_decrypt_o),
        .core_valid_i   (core_valid_i),
        .core_data_i    (core_data_i),
        .busy_o         (busy_o)
    );

    int errs = 0;
    int checks = 0;

    int t = 0, rr = 0, id = 0, tg = 0, ta = -100, tr = 0;
    bit act = 0, kinv = 0, kerr = 0, tmo = 0;
    bit pend [N];
    bit pdec [N];
    logic [127:0] pdata [N];
    logic [127:0] xdata = '0, xexp = '0, cin = '0, ovr = '0;
    bit xdec = 0, cdec = 0, ovr_en = 0;
    bit rst_drv = 0, key = 1, gen = 0, spur_en = 0;
    int lat_sel = -1, fill_pct = 0;
    int gq [$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, t);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Stand-in for the cipher: any fixed, mode-dependent transform will do.
    function automatic logic [127:0] aes_stub(input logic [127:0] d, input bit dec);
        if (dec) return d ^ 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
        return {d[63:0], d[127:64]} + 128'd7;
    endfunction

    function automatic int winner();
        for (int k = 0; k < N; k++) begin
            if (pend[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    function automatic bit any_pend();
        for (int i = 0; i < N; i++) begin
            if (pend[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int oh2idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic grant(input int w);
        int lat;
        act   = 1;
        id    = w;
        tg    = t;
        tmo   = 0;
        xdata = pdata[w];
        xdec  = pdec[w];
        xexp  = ovr_en ? ovr : aes_stub(xdata, xdec);
        pend[w] = 0;
        if (key) begin
            kinv = 0;
            kerr = 0;
            if (lat_sel >= 0) lat = lat_sel;
            else if ($urandom_range(0, 9) == 0) lat = 20;
            else lat = int'($urandom_range(0, 5));
            ta = t + 1 + lat;
            tr = ta + 1;
`ifdef IBEX_AES_ARB_TIMEOUT_EN
            if (ta > t + 1 + Tmo) begin
                tr  = t + 2 + Tmo;
                tmo = 1;
            end
`endif
        end else begin
            kinv = 1;
            kerr = 1;
            tr   = t + 1;
            ta   = -100;
        end
    endtask

    task automatic tick();
        int w;
        logic [N-1:0] xr, xv;
        bit xcv;
        @(posedge clk_i);
        #1;
        if (core_valid_o) begin
            cin  = core_data_o;
            cdec = core_decrypt_o;
        end
        rst_ni      = rst_drv;
        key_valid_i = key;
        for (int i = 0; i < N; i++) begin
            req_valid_i[i] = rst_drv && pend[i];
            req_data_i[AesBlockW*i +: AesBlockW] = pdata[i];
            req_decrypt_i[i] = pdec[i];
        end
        core_valid_i = 1'b0;
        core_data_i  = rnd128();
        if (t == ta) begin
            core_valid_i = 1'b1;
            core_data_i  = ovr_en ? ovr : aes_stub(cin, cdec);
        end else if (spur_en && (!act || t == tr) && $urandom_range(0, 7) == 0) begin
            core_valid_i = 1'b1;
        end

        @(negedge clk_i);
        if (!rst_drv) begin
            chk("rst_ready", 128'(req_ready_o), '0);
            chk("rst_rsp_valid", 128'(rsp_valid_o), '0);
            chk("rst_rsp_data", rsp_data_o, '0);
            chk("rst_rsp_error", 128'(rsp_error_o), '0);
            chk("rst_core_valid", 128'(core_valid_o), '0);
            chk("rst_core_data", core_data_o, '0);
            chk("rst_core_dec", 128'(core_decrypt_o), '0);
            chk("rst_busy", 128'(busy_o), '0);
            act = 0;
            rr  = 0;
            for (int i = 0; i < N; i++) pend[i] = 0;
        end else begin
            w   = act ? -1 : winner();
            xr  = (w >= 0) ? (N'(1) << w) : '0;
            xv  = (act && t == tr) ? (N'(1) << id) : '0;
            xcv = act && !kinv && (t == tg + 1);
            if (act && !kinv && t > tg && t < tr && !key) kerr = 1;
            chk("ready", 128'(req_ready_o), 128'(xr));
            chk("busy", 128'(busy_o), 128'(act));
            chk("core_valid", 128'(core_valid_o), 128'(xcv));
            chk("rsp_valid", 128'(rsp_valid_o), 128'(xv));
            if (act && t > tg) chk("core_data", core_data_o, xdata);
            if (xcv) chk("core_dec", 128'(core_decrypt_o), 128'(xdec));
            if (xv != '0) begin
                chk("rsp_data", rsp_data_o, (kerr || tmo) ? '0 : xexp);
                chk("rsp_error", 128'(rsp_error_o), 128'(kerr || tmo));
            end
            if (req_ready_o != '0) gq.push_back(oh2idx(req_ready_o));
            if (act && t == tr) begin
                rr  = (id + 1) % N;
                act = 0;
            end else if (w >= 0) begin
                grant(w);
            end
            if (gen) begin
                for (int i = 0; i < N; i++) begin
                    if (!pend[i] && int'($urandom_range(0, 99)) < fill_pct) begin
                        pend[i]  = 1;
                        pdata[i] = rnd128();
                        pdec[i]  = 1'($urandom_range(0, 1));
                    end
                end
            end
        end
        t++;
    endtask

    task automatic run_until_idle(input int max);
        int n = 0;
        while ((act || any_pend()) && n < max) begin
            tick();
            n++;
        end
        chk("drain", 128'(act || any_pend()), '0);
    endtask

    task automatic tick_to(input int k, input int max);
        int n = 0;
        while (!(act && t == tg + k) && n < max) begin
            tick();
            n++;
        end
        chk("reach", 128'(act && t == tg + k), 128'(1));
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            pend[i]  = 0;
            pdec[i]  = 0;
            pdata[i] = '0;
        end
        rst_drv = 0;
        repeat (2) tick();
        rst_drv = 1;
        tick();

        // single encrypt, answer 10 cycles after the start pulse
        pend[0] = 1; pdata[0] = 128'h1; pdec[0] = 0;
        lat_sel = 10; ovr_en = 1; ovr = 128'hAB;
        run_until_idle(40);
        ovr_en = 0; lat_sel = -1;

        // everyone requesting continuously from reset
        rst_drv = 0; tick(); rst_drv = 1;
        gq.delete();
        for (int i = 0; i < N; i++) begin
            pend[i]  = 1;
            pdata[i] = rnd128();
            pdec[i]  = 1'($urandom_range(0, 1));
        end
        gen = 1; fill_pct = 100;
        repeat (60) tick();
        gen = 0;
        run_until_idle(100);
        chk("order_len", 128'(gq.size() >= 4), 128'(1));
        if (gq.size() >= 4) begin
            chk("order0", 128'(gq[0]), 128'(0));
            chk("order1", 128'(gq[1]), 128'(1));
            chk("order2", 128'(gq[2]), 128'(2));
            chk("order3", 128'(gq[3]), 128'(0));
        end

        // key invalid at grant
        key = 0;
        pend[1] = 1; pdata[1] = rnd128(); pdec[1] = 1;
        run_until_idle(10);
        key = 1;

        // key lost while waiting on the cipher
        pend[0] = 1; pdata[0] = rnd128(); pdec[0] = 0;
        lat_sel = 6; ovr_en = 1; ovr = 128'h55;
        tick_to(3, 20);
        key = 0; tick(); key = 1;
        run_until_idle(20);
        ovr_en = 0;

        // reset in WAIT; the cipher's late answer must be dropped
        pend[1] = 1; pdata[1] = rnd128(); pdec[1] = 0;
        lat_sel = 8;
        tick_to(4, 20);
        rst_drv = 0; tick(); rst_drv = 1;
        repeat (8) tick();
        gq.delete();
        pend[0] = 1; pdata[0] = rnd128();
        pend[1] = 1; pdata[1] = rnd128();
        lat_sel = 2;
        run_until_idle(40);
        chk("rr_rst_len", 128'(gq.size() >= 1), 128'(1));
        if (gq.size() >= 1) chk("rr_rst", 128'(gq[0]), 128'(0));

`ifdef IBEX_AES_ARB_TIMEOUT_EN
        // silent cipher, late answer 5 cycles after the abort
        pend[2] = 1; pdata[2] = rnd128(); pdec[2] = 1;
        lat_sel = Tmo + 6;
        run_until_idle(40);
        repeat (8) tick();
        pend[0] = 1; pdata[0] = rnd128();
        lat_sel = 3;
        run_until_idle(20);
`endif

        // random traffic with key glitches and stray cipher pulses
        lat_sel = -1; gen = 1; fill_pct = 30; spur_en = 1;
        for (int i = 0; i < 1500; i++) begin
            key = ($urandom_range(0, 19) != 0);
            tick();
        end
        gen = 0; key = 1;
        run_until_idle(200);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
